// File: rtl/link_pkg.sv
// Shared SC register layout, default divider reloads and readback fill for the CGB serial link.
package link_pkg;

  localparam int SC_START = 7;
  localparam int SC_FAST  = 1;
  localparam int SC_INT   = 0;

  localparam int DIV_SLOW = 511;
  localparam int DIV_FAST = 15;

  localparam logic [4:0] SC_FILL = 5'b11111;

  // Tick count at which the internal clock drops low within a bit period.
  function automatic int div_half(input int reload);
    return (reload + 1) / 2;
  endfunction

endpackage

// File: rtl/link_sync.sv
// Synchronises the partner's serial clock and flags its edges as one-clk pulses.
// Latency SYNC_STAGES+1 clk from pin to pulse; no backpressure, edges are never held.
module link_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Idle-high reset keeps a released cable from looking like a falling edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/link_cgb.sv
// CGB serial link port: SB shift register, SC control, internal/fast/external clocking, irq.
// Register writes take effect on the next clk; the cable has no flow control, so bits are never stalled.
module link_cgb
  import link_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLK_DIV_SLOW = DIV_SLOW,
  parameter int CLK_DIV_FAST = DIV_FAST,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel_sc,
  input  logic              sel_sb,
  input  logic              cpu_wr_n,
  input  logic [7:0]        cpu_di,
  input  logic              cgb_mode,
  input  logic              double_speed,
  input  logic              serial_clk_in,
  input  logic              serial_data_in,
  output logic              serial_clk_out,
  output logic              serial_data_out,
  output logic [DATA_W-1:0] sb,
  output logic [7:0]        sc_dout,
  output logic              serial_irq,
  output logic              busy
);

  localparam int DIV_MAX = (CLK_DIV_SLOW > CLK_DIV_FAST) ? CLK_DIV_SLOW : CLK_DIV_FAST;
  localparam int DIV_W   = $clog2(DIV_MAX + 1);
  localparam int CNT_W   = $clog2(DATA_W + 1);
  localparam int WR_W    = (DATA_W < 8) ? DATA_W : 8;

  localparam logic [DIV_W-1:0] RLD_SLOW  = DIV_W'(CLK_DIV_SLOW);
  localparam logic [DIV_W-1:0] RLD_FAST  = DIV_W'(CLK_DIV_FAST);
  localparam logic [DIV_W-1:0] HALF_SLOW = DIV_W'(div_half(CLK_DIV_SLOW));
  localparam logic [DIV_W-1:0] HALF_FAST = DIV_W'(div_half(CLK_DIV_FAST));
  localparam logic [CNT_W-1:0] CNT_RLD   = CNT_W'(DATA_W);

  logic              toggle_q, toggle_d;
  logic              sc_start_q, sc_start_d;
  logic              sc_int_q, sc_int_d;
  logic              sc_fast_q, sc_fast_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  div_sel_q, div_sel_d;
  logic [DIV_W-1:0]  half_q, half_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sb_q, sb_d;
  logic              clk_out_q, clk_out_d;
  logic              data_out_q, data_out_d;
  logic              irq_q, irq_d;

  logic              sc_wr, sb_wr, tick, ext_rise, ext_fall;
  logic [DATA_W-1:0] sb_wr_val, sb_shift;

  link_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .async_i(serial_clk_in),
    .rise_o (ext_rise),
    .fall_o (ext_fall)
  );

  assign sc_wr    = sel_sc & ~cpu_wr_n;
  assign sb_wr    = sel_sb & ~cpu_wr_n;
  assign tick     = double_speed | toggle_q;
  assign sb_shift = {sb_q[DATA_W-2:0], serial_data_in};

  always_comb begin
    sb_wr_val             = '0;
    sb_wr_val[WR_W-1:0]   = cpu_di[WR_W-1:0];
  end

  always_comb begin
    toggle_d   = ~toggle_q;
    sc_start_d = sc_start_q;
    sc_int_d   = sc_int_q;
    sc_fast_d  = sc_fast_q;
    div_d      = div_q;
    div_sel_d  = div_sel_q;
    half_d     = half_q;
    cnt_d      = cnt_q;
    sb_d       = sb_q;
    clk_out_d  = clk_out_q;
    data_out_d = data_out_q;
    irq_d      = 1'b0;

    if (sc_wr) begin
      // Any SC write parks the clock high; a start bit also restarts the bit timing.
      sc_start_d = cpu_di[SC_START];
      sc_int_d   = cpu_di[SC_INT];
      sc_fast_d  = cpu_di[SC_FAST] & cgb_mode;
      clk_out_d  = 1'b1;
      cnt_d      = CNT_RLD;
      if (cpu_di[SC_START]) begin
        div_sel_d = sc_fast_d ? RLD_FAST : RLD_SLOW;
        half_d    = sc_fast_d ? HALF_FAST : HALF_SLOW;
        div_d     = div_sel_d;
      end
    end else if (sb_wr) begin
      sb_d = sb_wr_val;
    end else if (sc_start_q) begin
      if (cnt_q == '0) begin
        irq_d      = 1'b1;
        sc_start_d = 1'b0;
        cnt_d      = CNT_RLD;
      end else if (sc_int_q) begin
        if (tick) begin
          if (div_q == '0) begin
            clk_out_d = 1'b1;
            sb_d      = sb_shift;
            cnt_d     = cnt_q - CNT_W'(1);
            div_d     = div_sel_q;
          end else begin
            div_d = div_q - DIV_W'(1);
            if (div_q == half_q) begin
              clk_out_d  = 1'b0;
              data_out_d = sb_q[DATA_W-1];
            end
          end
        end
      end else begin
        if (ext_fall) data_out_d = sb_q[DATA_W-1];
        if (ext_rise) begin
          sb_d  = sb_shift;
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle_q   <= 1'b0;
      sc_start_q <= 1'b0;
      sc_int_q   <= 1'b0;
      sc_fast_q  <= 1'b0;
      div_q      <= '0;
      div_sel_q  <= RLD_SLOW;
      half_q     <= HALF_SLOW;
      cnt_q      <= CNT_RLD;
      sb_q       <= '0;
      clk_out_q  <= 1'b1;
      data_out_q <= 1'b1;
      irq_q      <= 1'b0;
    end else begin
      toggle_q   <= toggle_d;
      sc_start_q <= sc_start_d;
      sc_int_q   <= sc_int_d;
      sc_fast_q  <= sc_fast_d;
      div_q      <= div_d;
      div_sel_q  <= div_sel_d;
      half_q     <= half_d;
      cnt_q      <= cnt_d;
      sb_q       <= sb_d;
      clk_out_q  <= clk_out_d;
      data_out_q <= data_out_d;
      irq_q      <= irq_d;
    end
  end

  assign serial_clk_out  = clk_out_q;
  assign serial_data_out = data_out_q;
  assign sb              = sb_q;
  assign serial_irq      = irq_q;
  assign busy            = sc_start_q;
  assign sc_dout         = {sc_start_q, SC_FILL, cgb_mode ? sc_fast_q : 1'b1, sc_int_q};

endmodule

// File: tb/tb_link_cgb.sv
// Directed bench for link_cgb: scoreboarded serial bits, bit timing, irq, abort and reset.
module tb_link_cgb;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel_sc, sel_sb, cpu_wr_n;
  logic [7:0] cpu_di;
  logic       cgb_mode, double_speed;
  logic       serial_clk_in, serial_data_in;
  logic       serial_clk_out, serial_data_out;
  logic [7:0] sb;
  logic [7:0] sc_dout;
  logic       serial_irq, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int irq_cnt = 0;
  int irq_at = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  link_cgb dut (
    .clk            (clk),
    .rst            (rst),
    .sel_sc         (sel_sc),
    .sel_sb         (sel_sb),
    .cpu_wr_n       (cpu_wr_n),
    .cpu_di         (cpu_di),
    .cgb_mode       (cgb_mode),
    .double_speed   (double_speed),
    .serial_clk_in  (serial_clk_in),
    .serial_data_in (serial_data_in),
    .serial_clk_out (serial_clk_out),
    .serial_data_out(serial_data_out),
    .sb             (sb),
    .sc_dout        (sc_dout),
    .serial_irq     (serial_irq),
    .busy           (busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (serial_irq === 1'b1) begin
      irq_cnt++;
      irq_at = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_wr(input bit is_sc, input logic [7:0] d);
    @(negedge clk);
    sel_sc   = is_sc;
    sel_sb   = ~is_sc;
    cpu_di   = d;
    cpu_wr_n = 1'b0;
    @(negedge clk);
    sel_sc   = 1'b0;
    sel_sb   = 1'b0;
    cpu_wr_n = 1'b1;
  endtask

  task automatic push_bits(input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) exp_q.push_back(v[i]);
  endtask

  // Follows serial_clk_out; each falling edge pops one expected data bit.
  task automatic run_xfer(input string tag, input int budget, input int stop_rises,
                          output int period, output int rise_last, output int nf, output int nr);
    logic pclk;
    int   f0;
    pclk = serial_clk_out;
    f0 = 0; nf = 0; nr = 0; period = 0; rise_last = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (pclk && !serial_clk_out) begin
        nf++;
        if (nf == 1) f0 = c;
        else if (nf == 2) period = c - f0;
        if (exp_q.size() > 0) check({tag, "_bit"}, serial_data_out, exp_q.pop_front());
      end
      if (!pclk && serial_clk_out) begin
        nr++;
        rise_last = c;
      end
      pclk = serial_clk_out;
      if (nr >= stop_rises || !busy) break;
    end
  endtask

  initial begin
    int per, rl, nf, nr, irq0, k, d;
    logic [7:0] pat;

    rst = 1'b1; sel_sc = 1'b0; sel_sb = 1'b0; cpu_wr_n = 1'b1; cpu_di = 8'h00;
    cgb_mode = 1'b0; double_speed = 1'b0; serial_clk_in = 1'b1; serial_data_in = 1'b1;
    #12;
    check("rst_sb", sb, 8'h00);
    check("rst_clk_out", serial_clk_out, 1'b1);
    check("rst_data_out", serial_data_out, 1'b1);
    check("rst_irq", serial_irq, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sc_dout", sc_dout, 8'h7E);
    @(negedge clk);
    rst = 1'b0;

    // Internal slow clock, normal speed.
    cpu_wr(1'b0, 8'hA5);
    check("t1_sb_wr", sb, 8'hA5);
    push_bits(8'hA5, 8);
    irq0 = irq_cnt;
    cpu_wr(1'b1, 8'h81);
    check("t1_busy", busy, 1'b1);
    run_xfer("t1", 9000, 8, per, rl, nf, nr);
    check("t1_period", per, 1024);
    check("t1_falls", nf, 8);
    check("t1_q_empty", exp_q.size(), 0);
    repeat (5) @(negedge clk);
    check("t1_irq_once", irq_cnt - irq0, 1);
    check("t1_sb", sb, 8'hFF);
    check("t1_sc_dout", sc_dout, 8'h7F);
    check("t1_busy_end", busy, 1'b0);

    // CGB fast clock in double speed.
    cgb_mode = 1'b1; double_speed = 1'b1; serial_data_in = 1'b0;
    cpu_wr(1'b0, 8'h5A);
    push_bits(8'h5A, 8);
    irq0 = irq_cnt;
    cpu_wr(1'b1, 8'h83);
    check("t2_sc_dout_busy", sc_dout, 8'hFF);
    run_xfer("t2", 400, 8, per, rl, nf, nr);
    check("t2_period", per, 16);
    check("t2_last_rise", rl, 128);
    check("t2_q_empty", exp_q.size(), 0);
    repeat (5) @(negedge clk);
    check("t2_irq_once", irq_cnt - irq0, 1);
    check("t2_sb", sb, 8'h00);
    check("t2_sc_dout_end", sc_dout, 8'h7F);

    // Fast bit requested without CGB mode: slow clock stays in use.
    cgb_mode = 1'b0; double_speed = 1'b0; serial_data_in = 1'b1;
    cpu_wr(1'b0, 8'h96);
    push_bits(8'h96, 2);
    cpu_wr(1'b1, 8'h83);
    check("t6_sc_dout", sc_dout, 8'hFF);
    run_xfer("t6", 3000, 2, per, rl, nf, nr);
    check("t6_period", per, 1024);
    check("t6_rises", nr, 2);
    cpu_wr(1'b1, 8'h00);
    exp_q.delete();

    // External clock from partner, data 0x3C MSB first.
    pat = 8'h3C;
    cpu_wr(1'b0, 8'h00);
    irq0 = irq_cnt;
    cpu_wr(1'b1, 8'h80);
    k = 0;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      serial_clk_in = 1'b0;
      serial_data_in = pat[i];
      exp_q.push_back(1'b0);
      repeat (100) @(negedge clk);
      check("t3_partner_sample", serial_data_out, exp_q.pop_front());
      check("t3_clk_out", serial_clk_out, 1'b1);
      serial_clk_in = 1'b1;
      k = cyc;
      repeat (100) @(negedge clk);
    end
    d = irq_at - k;
    check("t3_sb", sb, 8'h3C);
    check("t3_irq_once", irq_cnt - irq0, 1);
    check("t3_irq_delay", (d >= 2 && d <= 4), 1'b1);
    check("t3_busy", busy, 1'b0);

    // Abort after three bits.
    serial_data_in = 1'b1;
    cpu_wr(1'b0, 8'h0F);
    push_bits(8'h0F, 3);
    cpu_wr(1'b1, 8'h81);
    run_xfer("t4", 4000, 3, per, rl, nf, nr);
    check("t4_rises", nr, 3);
    irq0 = irq_cnt;
    cpu_wr(1'b1, 8'h01);
    check("t4_busy", busy, 1'b0);
    check("t4_clk_out", serial_clk_out, 1'b1);
    check("t4_sb_partial", sb, 8'h7F);
    check("t4_sc_dout", sc_dout, 8'h7F);
    repeat (2000) @(negedge clk);
    check("t4_sb_hold", sb, 8'h7F);
    check("t4_clk_hold", serial_clk_out, 1'b1);
    check("t4_no_irq", irq_cnt - irq0, 0);

    // Asynchronous reset in the middle of a bit.
    cgb_mode = 1'b1; double_speed = 1'b1; serial_data_in = 1'b0;
    cpu_wr(1'b0, 8'h0F);
    cpu_wr(1'b1, 8'h83);
    repeat (44) @(negedge clk);
    check("t5_mid_clk_low", serial_clk_out, 1'b0);
    check("t5_mid_sb", sb, 8'h3C);
    #2 rst = 1'b1;
    #1;
    check("t5_sb", sb, 8'h00);
    check("t5_clk_out", serial_clk_out, 1'b1);
    check("t5_data_out", serial_data_out, 1'b1);
    check("t5_irq", serial_irq, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_sc_dout", sc_dout, 8'h7C);
    irq0 = irq_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    check("t5_no_irq", irq_cnt - irq0, 0);
    check("t5_busy_after", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
